// File: rtl/fa4_pkg.sv
// Shared constants and result type for the 4-bit ripple-carry adder.
package fa4_pkg;
    localparam int WIDTH = 4;

    typedef struct packed {
        logic       cout;
        logic [3:0] sum;
    } fa4_result_t;
endpackage

// File: rtl/fa4_interface.sv
// Signal bundle for fa4_adder with adder-side and bench-side views.
interface fa4_interface #(
    parameter int WIDTH = fa4_pkg::WIDTH
);
    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [WIDTH:0]   sum_q;
    logic             ovf_q;

    modport dut (
        input  clk, rst_n, a, b, cin,
        output sum, cout, ovf, sum_q, ovf_q
    );

    modport tb (
        output clk, rst_n, a, b, cin,
        input  sum, cout, ovf, sum_q, ovf_q
    );
endinterface

// File: rtl/fa4_adder_fa.sv
// One-bit full adder; the building block of the ripple chain.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/fa4_adder.sv
// Ripple-carry adder with combinational sum/carry/overflow and a registered
// copy of {cout, sum} and overflow for downstream synchronous logic.
module fa4_adder #(
    parameter int WIDTH = fa4_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH:0]   sum_q,
    output logic             ovf_q
);
    import fa4_pkg::fa4_result_t;

    logic [WIDTH:0] carry;
    fa4_result_t    result_next;
    fa4_result_t    result_reg;
    logic           ovf_reg;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
            fa u_fa (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (carry[gi]),
                .sum  (sum[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign cout = carry[WIDTH];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf  = carry[WIDTH-1] ^ carry[WIDTH];

    assign result_next = fa4_result_t'({cout, sum});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            result_reg <= result_next;
            ovf_reg    <= ovf;
        end
    end

    assign sum_q = result_reg;
    assign ovf_q = ovf_reg;
endmodule

// File: tb/tb_fa4_adder.sv
// Scoreboard bench for fa4_adder: combinational sweep, corner cases,
// registered path, asynchronous reset behaviour.
module tb_fa4_adder;
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [4:0] res;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    fa4_interface #(.WIDTH(4)) bus ();

    fa4_adder #(.WIDTH(4)) dut (
        .clk   (bus.clk),
        .rst_n (bus.rst_n),
        .a     (bus.a),
        .b     (bus.b),
        .cin   (bus.cin),
        .sum   (bus.sum),
        .cout  (bus.cout),
        .ovf   (bus.ovf),
        .sum_q (bus.sum_q),
        .ovf_q (bus.ovf_q)
    );

    initial bus.clk = 1'b0;
    always #5 bus.clk = ~bus.clk;

    // Reference: integer addition and signed-range overflow test.
    function automatic exp_t model(input logic [3:0] ma, input logic [3:0] mb, input logic mc);
        exp_t e;
        int   s;
        e.a   = ma;
        e.b   = mb;
        e.cin = mc;
        e.res = 5'(int'(ma) + int'(mb) + int'(mc));
        s     = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
        e.ovf = (s > 7) || (s < -8);
        return e;
    endfunction

    task automatic drive(input logic [3:0] ta, input logic [3:0] tb_b, input logic tc);
        bus.a   = ta;
        bus.b   = tb_b;
        bus.cin = tc;
        sb.push_back(model(ta, tb_b, tc));
    endtask

    task automatic test_reset();
        bus.rst_n = 1'b0;
        drive(4'd9, 4'd9, 1'b1);
        #1;
        void'(sb.pop_front());
        vectors++;
        if ({bus.sum_q, bus.ovf_q} !== 6'b000000) begin
            miscompares++;
            $display("FAIL reset_async sum_q=%b ovf_q=%b exp sum_q=00000 ovf_q=0", bus.sum_q, bus.ovf_q);
        end
        vectors++;
        if ({bus.cout, bus.sum} !== 5'd19) begin
            miscompares++;
            $display("FAIL reset_comb a=9 b=9 cin=1 got %0d exp 19", {bus.cout, bus.sum});
        end
        @(posedge bus.clk);
        #1;
        vectors++;
        if (bus.sum_q !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_hold sum_q=%0d exp 0", bus.sum_q);
        end
        #1 bus.rst_n = 1'b1;
    endtask

    task automatic test_exhaustive();
        exp_t e;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    drive(4'(ia), 4'(ib), 1'(ic));
                    #10;
                    e = sb.pop_front();
                    vectors++;
                    if ({bus.cout, bus.sum, bus.ovf} !== {e.res, e.ovf}) begin
                        miscompares++;
                        $display("FAIL sweep a=%0d b=%0d cin=%0d got cout=%b sum=%0d ovf=%b exp cout=%b sum=%0d ovf=%b",
                                 e.a, e.b, e.cin, bus.cout, bus.sum, bus.ovf, e.res[4], e.res[3:0], e.ovf);
                    end
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [13:0] tbl [4];
        exp_t e;
        // {a, b, cin, sum, cout}
        tbl[0] = {4'd15, 4'd5,  1'b0, 4'd4,  1'b1};
        tbl[1] = {4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        tbl[2] = {4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
        tbl[3] = {4'd15, 4'd0,  1'b1, 4'd0,  1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i][13:10], tbl[i][9:6], tbl[i][5]);
            #10;
            e = sb.pop_front();
            vectors++;
            if ({bus.sum, bus.cout} !== tbl[i][4:0]) begin
                miscompares++;
                $display("FAIL wrap a=%0d b=%0d cin=%0d got sum=%0d cout=%b exp sum=%0d cout=%b",
                         e.a, e.b, e.cin, bus.sum, bus.cout, tbl[i][4:1], tbl[i][0]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [14:0] tbl [3];
        exp_t e;
        // {a, b, cin, ovf, cout, sum}
        tbl[0] = {4'd7, 4'd1, 1'b0, 1'b1, 1'b0, 4'd8};
        tbl[1] = {4'd8, 4'd8, 1'b0, 1'b1, 1'b1, 4'd0};
        tbl[2] = {4'd3, 4'd2, 1'b0, 1'b0, 1'b0, 4'd5};
        for (int i = 0; i < 3; i++) begin
            drive(tbl[i][14:11], tbl[i][10:7], tbl[i][6]);
            #10;
            e = sb.pop_front();
            vectors++;
            if ({bus.ovf, bus.cout, bus.sum} !== tbl[i][5:0]) begin
                miscompares++;
                $display("FAIL overflow a=%0d b=%0d cin=%0d got ovf=%b cout=%b sum=%0d exp ovf=%b cout=%b sum=%0d",
                         e.a, e.b, e.cin, bus.ovf, bus.cout, bus.sum, tbl[i][5], tbl[i][4], tbl[i][3:0]);
            end
        end
    endtask

    task automatic test_registered();
        exp_t e;
        @(negedge bus.clk);
        drive(4'd9, 4'd9, 1'b1);
        @(posedge bus.clk);
        #1;
        e = sb.pop_front();
        vectors++;
        if (bus.sum_q !== 5'b10011 || bus.sum_q !== e.res || bus.ovf_q !== e.ovf) begin
            miscompares++;
            $display("FAIL registered a=9 b=9 cin=1 got sum_q=%0d ovf_q=%b exp sum_q=19 ovf_q=%b",
                     bus.sum_q, bus.ovf_q, e.ovf);
        end
    endtask

    task automatic test_mid_reset();
        #2 bus.rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.sum_q !== 5'd0 || bus.ovf_q !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_regs sum_q=%0d ovf_q=%b exp 0/0", bus.sum_q, bus.ovf_q);
        end
        vectors++;
        if (bus.sum !== 4'd3 || bus.cout !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_comb a=9 b=9 cin=1 got sum=%0d cout=%b exp sum=3 cout=1", bus.sum, bus.cout);
        end
        @(negedge bus.clk);
        bus.rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [4:0] held;
        for (int i = 0; i < 24; i++) begin
            @(negedge bus.clk);
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            @(posedge bus.clk);
            #1;
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL b2b_scoreboard_empty step=%0d", i);
                continue;
            end
            e = sb.pop_front();
            vectors++;
            if (bus.sum_q !== e.res || bus.ovf_q !== e.ovf) begin
                miscompares++;
                $display("FAIL b2b a=%0d b=%0d cin=%0d got sum_q=%0d ovf_q=%b exp sum_q=%0d ovf_q=%b",
                         e.a, e.b, e.cin, bus.sum_q, bus.ovf_q, e.res, e.ovf);
            end
            // Register must hold across an input change between edges.
            held    = e.res;
            bus.a   = ~e.a;
            bus.b   = e.b + 4'd3;
            #2;
            vectors++;
            if (bus.sum_q !== held) begin
                miscompares++;
                $display("FAIL b2b_hold got sum_q=%0d exp %0d", bus.sum_q, held);
            end
        end
    endtask

    initial begin
        bus.a   = '0;
        bus.b   = '0;
        bus.cin = 1'b0;
        test_reset();
        test_exhaustive();
        test_wrap();
        test_overflow();
        test_registered();
        test_mid_reset();
        test_back_to_back();
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_leftover entries=%0d", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
